// File: rtl/eth_pkt_wr_arb_if.sv
// Signal bundle around the packet write arbiter: source handshakes, FIFO write port and status.
// Names carry the arbiter's view: i_ flows into the arbiter, o_ flows out of it.
interface eth_pkt_wr_arb_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
);
    logic [NUM_SRC-1:0]            i_src_req;
    logic [NUM_SRC*LEN_WIDTH-1:0]  i_src_len;
    logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data;
    logic [NUM_SRC-1:0]            i_src_valid;
    logic [NUM_SRC-1:0]            o_src_ready;
    logic [NUM_SRC-1:0]            o_src_grant;
    logic [DATA_WIDTH-1:0]         o_fifo_wr_data;
    logic                          o_fifo_wr_en;
    logic                          i_fifo_full;
    logic [LEN_WIDTH-1:0]          i_fifo_wr_water_level;
    logic                          o_busy;
    logic [$clog2(NUM_SRC)-1:0]    o_cur_src;
    logic                          o_pkt_done;
    logic                          o_err_len;

    modport master (
        input  i_src_req, i_src_len, i_src_data, i_src_valid,
        input  i_fifo_full, i_fifo_wr_water_level,
        output o_src_ready, o_src_grant, o_fifo_wr_data, o_fifo_wr_en,
        output o_busy, o_cur_src, o_pkt_done, o_err_len
    );

    modport slave (
        output i_src_req, i_src_len, i_src_data, i_src_valid,
        output i_fifo_full, i_fifo_wr_water_level,
        input  o_src_ready, o_src_grant, o_fifo_wr_data, o_fifo_wr_en,
        input  o_busy, o_cur_src, o_pkt_done, o_err_len
    );
endinterface

// File: rtl/eth_pkt_wr_arb.sv
// Round-robin whole-packet write arbiter: four sources share one packet FIFO, each packet
// is preceded by a {tag, length} header word and only granted when the FIFO can hold it all.
module eth_pkt_wr_arb #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          LEN_WIDTH  = 11,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] HDR_TAG    = 16'hA55A
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst_n,
    eth_pkt_wr_arb_if.master bus
);
    localparam int NUM_SRC = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN    = LEN_WIDTH'((1 << ADDR_WIDTH) - 1);
    localparam logic [LEN_WIDTH:0]   FIFO_DEPTH = (LEN_WIDTH + 1)'(1 << ADDR_WIDTH);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [1:0]            r_rr_ptr;
    logic [1:0]            r_cur_src;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [2:0]            r_gap;
    logic [NUM_SRC-1:0]    r_grant;
    logic                  r_err;
    logic                  r_done;
    logic                  r_busy;

    logic [LEN_WIDTH-1:0]  w_len_arr  [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_SRC];

    logic [1:0]            w_cand;
    logic                  w_any;
    logic [LEN_WIDTH-1:0]  w_cand_len;
    logic                  w_len_bad;
    logic [LEN_WIDTH:0]    w_need;
    logic                  w_space_ok;
    logic                  w_arb;
    logic                  w_take;
    logic                  w_reject;
    logic                  w_data_wr;
    logic                  w_last;

    logic [NUM_SRC-1:0]    w_src_ready;
    logic                  w_fifo_wr_en;
    logic [DATA_WIDTH-1:0] w_fifo_wr_data;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_len_arr[gi]  = bus.i_src_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign w_data_arr[gi] = bus.i_src_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan downward so the requester closest to the pointer is the one left standing.
    always_comb begin
        w_cand = r_rr_ptr;
        w_any  = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (bus.i_src_req[r_rr_ptr + 2'(k)]) begin
                w_cand = r_rr_ptr + 2'(k);
                w_any  = 1'b1;
            end
        end
    end

    assign w_cand_len = w_len_arr[w_cand];
    assign w_len_bad  = (w_cand_len == '0) || (w_cand_len > MAX_LEN);
    assign w_need     = {1'b0, bus.i_fifo_wr_water_level} + {1'b0, w_cand_len} + (LEN_WIDTH + 1)'(1);
    assign w_space_ok = (w_need <= FIFO_DEPTH);

    // The cycle carrying a rejection pulse is skipped so the source can retract its request.
    assign w_arb    = (r_state == S_IDLE) && w_any && !r_err;
    assign w_take   = w_arb && !w_len_bad && w_space_ok;
    assign w_reject = w_arb && w_len_bad;

    assign w_data_wr = (r_state == S_DATA) && bus.i_src_valid[r_cur_src] && !bus.i_fifo_full;
    assign w_last    = w_data_wr && (LEN_WIDTH'(r_cnt) == r_len - LEN_WIDTH'(1));

    always_comb begin
        w_fifo_wr_en   = 1'b0;
        w_fifo_wr_data = '0;
        w_src_ready    = '0;
        case (r_state)
            S_HDR: begin
                w_fifo_wr_en   = !bus.i_fifo_full;
                w_fifo_wr_data = {HDR_TAG, {(DATA_WIDTH - 16 - LEN_WIDTH){1'b0}}, r_len};
            end
            S_DATA: begin
                w_src_ready[r_cur_src] = !bus.i_fifo_full;
                w_fifo_wr_en           = w_data_wr;
                w_fifo_wr_data         = w_data_arr[r_cur_src];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take)             w_state_next = S_HDR;
            S_HDR:   if (!bus.i_fifo_full)   w_state_next = S_DATA;
            S_DATA:  if (w_last)             w_state_next = S_GAP;
            S_GAP:   if (r_gap == 3'd0)      w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_cur_src <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_grant   <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_grant <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_reject) begin
                        r_grant  <= NUM_SRC'(1) << w_cand;
                        r_err    <= 1'b1;
                        r_rr_ptr <= w_cand + 2'd1;
                    end else if (w_take) begin
                        r_grant   <= NUM_SRC'(1) << w_cand;
                        r_cur_src <= w_cand;
                        r_len     <= w_cand_len;
                        r_cnt     <= '0;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_done   <= 1'b1;
                        r_rr_ptr <= r_cur_src + 2'd1;
                        r_cnt    <= '0;
                        r_gap    <= 3'(GAP_CYCLES - 1);
                    end else if (w_data_wr) begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap != 3'd0) r_gap <= r_gap - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_src_ready    = w_src_ready;
    assign bus.o_src_grant    = r_grant;
    assign bus.o_fifo_wr_en   = w_fifo_wr_en;
    assign bus.o_fifo_wr_data = w_fifo_wr_data;
    assign bus.o_busy         = r_busy;
    assign bus.o_cur_src      = r_cur_src;
    assign bus.o_pkt_done     = r_done;
    assign bus.o_err_len      = r_err;
endmodule

// File: tb/tb_eth_pkt_wr_arb.sv
// Directed bench for eth_pkt_wr_arb: one packet, round-robin order, space gating,
// backpressure, illegal lengths and asynchronous reset mid-packet.
module tb_eth_pkt_wr_arb;
    logic clk;
    logic rst_n;

    eth_pkt_wr_arb_if bus ();

    eth_pkt_wr_arb dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    // Monitor-owned state, sampled on the falling edge.
    logic [31:0] wr_q[$];
    int          grant_log[$];
    int          src_idx [4];
    int          grant_cnt = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          busy_cnt  = 0;

    int rr_exp  [5]  = '{0, 1, 2, 3, 0};
    bit bp_full [14] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit bp_valid[14] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int s, input int idx);
        return 32'hD000_0000 | (32'(s) << 16) | (32'(idx) & 32'h0000_FFFF);
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_src
            assign bus.i_src_data[gi*32 +: 32] = mk(gi, src_idx[gi]);
        end
    endgenerate

    initial for (int i = 0; i < 4; i++) src_idx[i] = 0;

    always @(negedge clk) begin
        if (bus.o_fifo_wr_en) wr_q.push_back(bus.o_fifo_wr_data);
        if (bus.o_src_grant != 4'b0) begin
            grant_cnt <= grant_cnt + 1;
            grant_log.push_back(onehot_idx(bus.o_src_grant));
            $display("grant src=%0d err_len=%0b t=%0t", onehot_idx(bus.o_src_grant), bus.o_err_len, $time);
        end
        if (bus.o_pkt_done) begin
            done_cnt <= done_cnt + 1;
            $display("pkt_done src=%0d t=%0t", bus.o_cur_src, $time);
        end
        if (bus.o_err_len) err_cnt <= err_cnt + 1;
        if (bus.o_busy) busy_cnt <= busy_cnt + 1;
        for (int i = 0; i < 4; i++)
            if (bus.i_src_valid[i] && bus.o_src_ready[i]) src_idx[i] <= src_idx[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int s, input int len);
        bus.i_src_len[s*11 +: 11] = 11'(len);
    endtask

    function automatic logic [31:0] status_vec();
        return 32'({bus.o_src_ready, bus.o_src_grant, bus.o_fifo_wr_en, bus.o_busy,
                    bus.o_pkt_done, bus.o_err_len, bus.o_cur_src});
    endfunction

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (bus.o_src_grant == 4'b0 && n < 60);
        check(tag, 32'(bus.o_src_grant), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy && n < 200) begin
            cyc();
            n++;
        end
        check(tag, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int wm, bm, dm, em, gm, b1;
    int base[4];
    int pos;

    initial begin
        rst_n                     = 1'b0;
        bus.i_src_req             = '0;
        bus.i_src_len             = '0;
        bus.i_src_valid           = '0;
        bus.i_fifo_full           = 1'b0;
        bus.i_fifo_wr_water_level = '0;
        repeat (3) cyc();

        // Reset state
        check("reset_status", status_vec(), 32'd0);
        check("reset_wr_data", bus.o_fifo_wr_data, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single packet, source 1, len 3
        wm = wr_q.size(); bm = busy_cnt; dm = done_cnt; b1 = src_idx[1];
        set_len(1, 3);
        bus.i_src_valid = 4'hF;
        bus.i_src_req   = 4'b0010;
        wait_grant("single_grant", 4'b0010);
        bus.i_src_req = 4'b0000;
        #1;
        check("single_cur_src", 32'(bus.o_cur_src), 32'd1);
        check("single_hdr_en", 32'(bus.o_fifo_wr_en), 32'd1);
        check("single_hdr_data", bus.o_fifo_wr_data, 32'hA55A_0003);
        check("single_err_len", 32'(bus.o_err_len), 32'd0);
        wait_idle("single_idle");
        check("single_busy_cycles", 32'(busy_cnt - bm), 32'd6);
        check("single_done_count", 32'(done_cnt - dm), 32'd1);
        check("single_word_count", 32'(wr_q.size() - wm), 32'd4);
        check("single_fifo_hdr", wr_q[wm], 32'hA55A_0003);
        for (int j = 0; j < 3; j++) check("single_fifo_data", wr_q[wm + 1 + j], mk(1, b1 + j));

        // Round-robin, all four sources request len 2
        do_reset();
        wm = wr_q.size(); gm = grant_log.size();
        for (int s = 0; s < 4; s++) begin
            base[s] = src_idx[s];
            set_len(s, 2);
        end
        bus.i_src_req = 4'hF;
        for (int n = 0; n < 300 && (grant_log.size() - gm) < 5; n++) cyc();
        bus.i_src_req = 4'b0000;
        wait_idle("rr_idle");
        check("rr_grant_count", 32'(grant_log.size() - gm), 32'd5);
        for (int k = 0; k < 5; k++) check("rr_order", 32'(grant_log[gm + k]), 32'(rr_exp[k]));
        check("rr_word_count", 32'(wr_q.size() - wm), 32'd15);
        for (int k = 0; k < 5; k++) begin
            pos = wm + 3 * k;
            check("rr_hdr", wr_q[pos], 32'hA55A_0002);
            check("rr_data0", wr_q[pos + 1], mk(rr_exp[k], base[rr_exp[k]]));
            check("rr_data1", wr_q[pos + 2], mk(rr_exp[k], base[rr_exp[k]] + 1));
            base[rr_exp[k]] = base[rr_exp[k]] + 2;
        end

        // Space gating at level 1020, released at 1019 (exactly fills 1024)
        do_reset();
        wm = wr_q.size(); gm = grant_cnt;
        bus.i_fifo_wr_water_level = 11'd1020;
        set_len(0, 4);
        set_len(1, 1);
        bus.i_src_req = 4'b0011;
        repeat (12) cyc();
        check("gate_no_grant", 32'(grant_cnt - gm), 32'd0);
        check("gate_not_busy", 32'(bus.o_busy), 32'd0);
        bus.i_fifo_wr_water_level = 11'd1019;
        wait_grant("gate_grant_src0", 4'b0001);
        bus.i_src_req = 4'b0000;
        bus.i_fifo_wr_water_level = 11'd0;
        wait_idle("gate_idle");
        check("gate_word_count", 32'(wr_q.size() - wm), 32'd5);
        check("gate_hdr", wr_q[wm], 32'hA55A_0004);

        // Backpressure on a len 8 packet from source 1
        wm = wr_q.size(); dm = done_cnt; b1 = src_idx[1];
        set_len(1, 8);
        bus.i_src_req = 4'b0010;
        wait_grant("bp_grant", 4'b0010);
        bus.i_src_req = 4'b0000;
        for (int j = 0; j < 14; j++) begin
            cyc();
            bus.i_fifo_full    = bp_full[j];
            bus.i_src_valid[1] = bp_valid[j];
            #1;
            if (bp_full[j]) check("bp_ready_wr_low", 32'({bus.o_src_ready[1], bus.o_fifo_wr_en}), 32'd0);
        end
        bus.i_fifo_full = 1'b0;
        bus.i_src_valid = 4'hF;
        wait_idle("bp_idle");
        check("bp_word_count", 32'(wr_q.size() - wm), 32'd9);
        check("bp_hdr", wr_q[wm], 32'hA55A_0008);
        for (int j = 0; j < 8; j++) check("bp_data", wr_q[wm + 1 + j], mk(1, b1 + j));
        check("bp_done_count", 32'(done_cnt - dm), 32'd1);

        // Illegal lengths from source 2: 0 then 1024
        wm = wr_q.size(); em = err_cnt;
        set_len(2, 0);
        bus.i_src_req = 4'b0100;
        wait_grant("ill_grant_len0", 4'b0100);
        check("ill_err_len0", 32'(bus.o_err_len), 32'd1);
        set_len(2, 1024);
        wait_grant("ill_grant_len1024", 4'b0100);
        check("ill_err_len1024", 32'(bus.o_err_len), 32'd1);
        bus.i_src_req = 4'b0000;
        repeat (3) cyc();
        check("ill_no_write", 32'(wr_q.size() - wm), 32'd0);
        check("ill_err_count", 32'(err_cnt - em), 32'd2);
        check("ill_not_busy", 32'(bus.o_busy), 32'd0);
        set_len(0, 1);
        set_len(3, 1);
        bus.i_src_req = 4'b1001;
        wait_grant("ill_ptr_at_3", 4'b1000);
        bus.i_src_req = 4'b0000;
        wait_idle("ill_idle");

        // Reset mid-packet: move pointer to 2, start len 10 from source 2, reset at word 5
        set_len(1, 0);
        bus.i_src_req = 4'b0010;
        wait_grant("rst_pre_reject", 4'b0010);
        bus.i_src_req = 4'b0000;
        cyc();
        cyc();
        set_len(2, 10);
        bus.i_src_req = 4'b0100;
        wait_grant("rst_grant_src2", 4'b0100);
        bus.i_src_req = 4'b0000;
        repeat (5) cyc();
        check("rst_mid_wr_en", 32'(bus.o_fifo_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_status", status_vec(), 32'd0);
        check("rst_async_wr_data", bus.o_fifo_wr_data, 32'd0);
        cyc();
        set_len(0, 2);
        set_len(2, 2);
        set_len(3, 2);
        bus.i_src_req = 4'b1101;
        cyc();
        rst_n = 1'b1;
        wait_grant("rst_first_src0", 4'b0001);
        bus.i_src_req = 4'b0000;
        wait_idle("rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
